div64by32: RTL

- Sequential unsigned divider: divides a 64-bit dividend by a 32-bit divisor and returns a 32-bit quotient and a 32-bit remainder.
- Inverse companion of the 32x32 multiplier; reuses its start/busy handshake so both blocks drop into the same arithmetic datapath.
- Radix-2 restoring algorithm: one quotient bit per clock.

---
 rtl/div64by32.sv | 70 +++++++
 1 files changed

// File: rtl/div64by32.sv
// div64by32: sequential radix-2 restoring unsigned divider, 64/32 -> 32-bit quotient and remainder.
// Optional macro DIV64BY32_EARLY_EXIT_EN skips the iterations when the dividend is already below the divisor.
module div64by32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] prem, sh, dv;
  logic [4:0]  cnt;
  logic        err, bad, early, ge;
  logic [32:0] r, d;
  assign bad = (b == 32'd0) || (a[63:32] >= b);
`ifdef DIV64BY32_EARLY_EXIT_EN
  assign early = (a[63:32] == 32'd0) && (a[31:0] < b);
`else
  assign early = 1'b0;
`endif
  // prem < dv keeps r below 2*dv, so the borrow bit of the 33-bit subtract is the compare result
  assign r  = {prem, sh[31]};
  assign d  = r - {1'b0, dv};
  assign ge = ~d[32];
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((bad || early) ? DONE : CALC) : IDLE;
      CALC:    state_nx = (cnt == 5'd31) ? DONE : CALC;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prem      <= '0;
      sh        <= '0;
      dv        <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          dv   <= b;
          err  <= bad;
          prem <= early ? a[31:0] : a[63:32];
          sh   <= early ? 32'd0 : a[31:0];
          cnt  <= '0;
        end
        CALC: begin
          prem <= ge ? d[31:0] : r[31:0];
          sh   <= {sh[30:0], ge};
          cnt  <= cnt + 5'd1;
        end
        default: begin
          quotient  <= err ? 32'hFFFFFFFF : sh;
          remainder <= err ? 32'hFFFFFFFF : prem;
        end
      endcase
    end
  end
endmodule
